// File: rtl/instr_encoder_loader_if.sv
// Instruction-load stream and instruction-memory write port of the encoder/loader.
// master drives the symbolic fields; slave is the loader itself.
interface instr_encoder_loader_if #(
    parameter int IW  = 9,
    parameter int OPW = 3,
    parameter int FW  = 3,
    parameter int AW  = 8
);
    logic              start;
    logic [AW-1:0]     base_addr;
    logic              in_valid;
    logic              in_ready;
    logic [OPW-1:0]    in_op;
    logic [FW-1:0]     in_a;
    logic [FW-1:0]     in_b;
    logic [IW-OPW-1:0] in_imm;
    logic              in_last;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [IW-1:0]     wr_data;
    logic              busy;
    logic              done;
    logic              err_overflow;
    logic [AW:0]       count;

    modport master (
        output start, base_addr, in_valid, in_op, in_a, in_b, in_imm, in_last,
        input  in_ready, wr_en, wr_addr, wr_data, busy, done, err_overflow, count
    );

    modport slave (
        input  start, base_addr, in_valid, in_op, in_a, in_b, in_imm, in_last,
        output in_ready, wr_en, wr_addr, wr_data, busy, done, err_overflow, count
    );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs symbolic instruction fields into machine words and writes them
// sequentially into instruction memory starting at a programmable base address.
//
// state | meaning
// IDLE  | no session; waiting for start
// LOAD  | session open; accepting fields, one write per transfer
// ERR   | address space exhausted before in_last; waiting for start
module instr_encoder_loader #(
    parameter int IW  = 9,
    parameter int OPW = 3,
    parameter int FW  = 3,
    parameter int AW  = 8
) (
    input logic                   clk,
    input logic                   reset,
    instr_encoder_loader_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, ERR} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   ptr;
    logic            xfer;
    logic            at_top;
    logic            sess_start;
    logic            is_jtype;
    logic [IW-1:0]   word;

    logic            wr_en_q;
    logic [AW-1:0]   wr_addr_q;
    logic [IW-1:0]   wr_data_q;
    logic            done_q;
    logic            err_q;
    logic [AW:0]     count_q;

    always_comb begin
        state_nxt  = state;
        xfer       = bus.in_valid && (state == LOAD);
        at_top     = (ptr == {AW{1'b1}});
        sess_start = bus.start && (state != LOAD);
        // The two top opcodes (BNE, SET) carry an immediate instead of register fields.
        is_jtype   = (bus.in_op[OPW-1 -: 2] == 2'b11);
        word       = is_jtype ? {bus.in_op, bus.in_imm} : {bus.in_op, bus.in_a, bus.in_b};
        case (state)
            IDLE, ERR: begin
                if (bus.start) state_nxt = LOAD;
            end
            LOAD: begin
                if (xfer) begin
                    if (bus.in_last)  state_nxt = IDLE;
                    else if (at_top)  state_nxt = ERR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            count_q   <= '0;
        end else begin
            state   <= state_nxt;
            wr_en_q <= xfer;
            done_q  <= xfer && bus.in_last;
            if (sess_start) begin
                ptr     <= bus.base_addr;
                count_q <= '0;
                err_q   <= 1'b0;
            end
            if (xfer) begin
                wr_addr_q <= ptr;
                wr_data_q <= word;
                count_q   <= count_q + 1'b1;
                // Pointer parks at the top address rather than wrapping to 0.
                if (!at_top) ptr <= ptr + 1'b1;
                if (at_top && !bus.in_last) err_q <= 1'b1;
            end
        end
    end

    assign bus.in_ready     = (state == LOAD);
    assign bus.busy         = (state == LOAD);
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.done         = done_q;
    assign bus.err_overflow = err_q;
    assign bus.count        = count_q;
endmodule

// File: doc/instr_encoder_loader.md
Name: instr_encoder_loader

Overview:
- Encoder/writer counterpart of the control decoder.
- Accepts symbolic instruction fields (opcode, register indices, immediate) over a valid/ready stream.
- Packs each into a 9-bit machine word and writes it sequentially into instruction memory from a programmable base address.
- Used at boot and by the testbench to load programs that the fetch/decode path later reads.

Parameters:
IW, 9, machine word width
OPW, 3, opcode field width (word bits [IW-1:IW-OPW])
FW, 3, register index field width
AW, 8, instruction memory address width (depth 2^AW)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  begin a load session at base_addr (honoured in IDLE and ERR only)
base_addr  input  AW  first write address of the session
in_valid  input  1  instruction fields valid
in_ready  output  1  loader can accept fields this cycle
in_op  input  OPW  opcode
in_a  input  FW  R-type first register field
in_b  input  FW  R-type second register field
in_imm  input  IW-OPW  J-type immediate
in_last  input  1  marks final instruction of the session
wr_en  output  1  instruction memory write strobe
wr_addr  output  AW  write address
wr_data  output  IW  encoded machine word
busy  output  1  session in progress
done  output  1  one-cycle pulse, session completed normally
err_overflow  output  1  sticky, address space exhausted before in_last
count  output  AW+1  words written in current/last session

Behaviour:
- Reset:
  - State IDLE.
  - in_ready, wr_en, busy, done, err_overflow = 0.
  - wr_addr, wr_data, count = 0.
  - Internal ptr = 0.
- Reset dominates every other input. A reset coinciding with a handshake discards that word: no wr_en on the following cycle.
- States: IDLE, LOAD, ERR.
  - in_ready = busy = (state == LOAD), both decoded from state.
- IDLE / ERR with start=1:
  - ptr <= base_addr, count <= 0, err_overflow <= 0, state <= LOAD.
  - in_ready rises on the next cycle.
- start in LOAD is ignored. in_valid in IDLE/ERR is ignored (no handshake).
- Transfer occurs when in_valid && in_ready at a rising edge. Latency is 1 cycle:
  - Next cycle: wr_en=1, wr_addr=ptr, wr_data=encoded word.
  - ptr <= ptr+1, count <= count+1.
  - wr_en is 0 in every cycle not following a transfer. wr_addr/wr_data hold their last values.
- Encoding, with word[8:6] = in_op:
  - R-type (op 000-101): word[5:3] = in_a, word[2:0] = in_b; in_imm ignored.
  - J-type (op 110 BNE, 111 SET): word[5:0] = in_imm; in_a/in_b ignored.
- Transfer with in_last=1:
  - state <= IDLE.
  - done=1 in the same cycle as that word's wr_en, for exactly one cycle.
  - in_ready drops the cycle after the transfer.
- Overflow: transfer at ptr == 2^AW-1 with in_last=0.
  - The word is still written at the all-ones address.
  - state <= ERR, err_overflow=1 in the cycle of that write.
  - in_ready drops; ptr never wraps to 0.
  - ERR holds until start or reset.
- A transfer at ptr == 2^AW-1 with in_last=1 is a normal completion: done pulses, no error.
- count saturates naturally at 2^AW (width AW+1). count holds after done/ERR until the next start.
- in_valid stalls (low in LOAD) are unlimited; no timeout.

Test Plan:
- Reset -> all outputs 0, in_ready 0. Assert in_valid=1 with no start -> no wr_en for 10 cycles.
- start with base_addr=0x10, then three back-to-back transfers:
  - (op=000, a=1, b=2), (op=101, a=3, b=0), (op=111, imm=0x2A, last=1)
  - -> writes 0x00A@0x10, 0x158@0x11, 0x1EA@0x12 on consecutive cycles.
  - -> done=1 only with the third write; count=3; busy=0 the following cycle.
- Same program with in_valid toggled 1,0,0,1,0,1 -> wr_en only on cycles after handshakes; addresses contiguous 0x10-0x12; data identical to the previous test.
- base_addr=0xFE, three non-last words offered continuously:
  - -> writes at 0xFE, 0xFF; err_overflow=1 with the 0xFF write.
  - -> in_ready=0; third word never accepted; count=2.
  - -> a later start clears err_overflow and reloads at base_addr.
- Mid-session reset asserted in the same cycle as in_valid&&in_ready -> no wr_en next cycle; all outputs at reset values.
- start pulsed during LOAD with base_addr=0x80 -> ignored; writes continue at ptr+1.
- J-type word with nonzero in_a/in_b (op=110, a=7, b=7, imm=0x05) -> wr_data=0x185.
